fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

- Consumes the streaming output of the radix-2² SDF FFT pipeline and re-emits each N-point frame in natural frequency-bin order.
- The FFT delivers each frame in bit-reversed index order.
- Sits between the last SDF stage and the magnitude/feature-extraction logic of the audio path.
- Uses a ping-pong frame buffer so that back-to-back frames stream with no stall and no gap.

## Interface
- N, 64, FFT point count; power of two, 4..1024; LOG_N = log2(N).
- WIDTH, 16, data bit length per real/imag component.

- clock  in  1  master clock, rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- di_en  in  1  input sample valid; one sample per cycle while high.
- di_re  in  WIDTH  input data, real; bit-reversed bin order.
- di_im  in  WIDTH  input data, imag.
- do_en  out  1  output sample valid.
- do_sof  out  1  high with bin 0 of each output frame.
- do_re  out  WIDTH  output data, real; natural bin order.
- do_im  out  WIDTH  output data, imag.

## Operation

**Buffer**
- Two banks of N complex words each.
- Write pointer wb and read pointer rb each select a bank.
- Per-bank full flag.

**Write side**
- Counter wc, LOG_N bits.
- On each edge with di_en=1: store {di_re, di_im} at bank[wb][bitrev(wc)], where bitrev mirrors bit i to bit LOG_N-1-i. Then increment wc.
- di_en=0 mid-frame: wc holds. The frame resumes when di_en returns; partial frames are never discarded except by reset.
- When wc wraps from N-1 to 0: set full[wb] and toggle wb.
- A write into a bank whose full flag is still set cannot occur. The input rate is at most one sample per cycle and the read side drains N samples in N cycles. The bench checks this with an assertion.

**Read side**
- FSM with states IDLE and READ, and a read counter rc of LOG_N bits.
- IDLE -> READ when full[rb]=1. rc=0.
- In READ, issue a read of bank[rb][rc] each cycle and increment rc.
- At rc=N-1: clear full[rb], toggle rb. If full[new rb] is already set, stay in READ with rc=0 (seamless), else go to IDLE.
- Memory read is synchronous: 1 cycle, then an output register.
- do_sof is asserted with the word read at rc=0.

**Outputs**
- do_re/do_im are registered.
- They are forced to 0 whenever do_en=0 (power saving).

**Arithmetic**
- No arithmetic on data; words pass bit-exact.

## Timing

**Reset values**
- do_en=0, do_sof=0, do_re=0, do_im=0.
- wc=0, rc=0, wb=0, rb=0, both full flags 0, FSM=IDLE.

**Latency**
- Let E be the edge capturing input sample index N-1 of a frame.
- Output bin k (do_en=1) is valid in the cycle after edge E+2+k, for k = 0..N-1.
- do_sof=1 only in the bin-0 cycle.

**Throughput**
- Continuous input (di_en high for F·N cycles) gives continuous output: do_en high for F·N consecutive cycles, starting 2 cycles after the first frame's last input.

**Simultaneous events**
- The read side clearing full[x] and the write side setting full[y] on the same edge is legal; x≠y is guaranteed.
- Frame completion on the same edge the reader toggles rb: the reader sees the new flag on the following cycle. No gap results, because the reader's decision is made on full[next bank] at rc=N-1.

**Reset mid-operation**
- Asynchronous assertion immediately forces outputs to reset values.
- Partially written or partially read frames are lost.
- After deassertion, the first sample with di_en=1 is index 0 of a new frame.

**Buffer contents**
- Memory contents are not reset; only the flags and counters are.

## Test plan
1. N=64, one frame, di_re=bitrev(k), di_im=-bitrev(k) for k=0..63 -> do_re=0,1,...,63 and do_im=0,-1,...,-63 in order. do_en high 64 cycles starting at E+2; do_sof high with 0 only.
2. Three back-to-back frames, di_re = frame·100 + bitrev(k) -> do_en high for exactly 192 consecutive cycles. Values 0..63, 100..163, 200..263; do_sof pulses at cycles 0, 64, 128 of the burst.
3. Frame with di_en low for 5 cycles after sample 20 -> output identical to scenario 1, first output shifted 5 cycles later.
4. Reset asserted at input sample 30 of frame 2, while frame 1 is draining -> do_en drops asynchronously. A fresh frame after release outputs correct natural order with no residue from frames 1 or 2.
5. N=16, WIDTH=8, data 0x80/0x7F patterns -> bit-exact natural-order reproduction. Latency E+2.
6. Random di_en duty (≥50%) over 50 frames versus a reference model -> all bins match. The no-write-into-full-bank assertion never fires; do_re/do_im are 0 whenever do_en=0.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Streaming sample bus for the bit-reversal reorder buffer: a bit-reversed
// input stream and a natural-order output stream with a start-of-frame marker.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 16
);
  logic                    di_en;
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic                    do_en;
  logic                    do_sof;
  logic signed [WIDTH-1:0] do_re;
  logic signed [WIDTH-1:0] do_im;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_sof, do_re, do_im
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_sof, do_re, do_im
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that turns bit-reversed FFT output frames into
// natural bin order, streaming back-to-back frames without stalls or gaps.
module fft_bitrev_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input logic            clock,
  input logic            reset,
  fft_bitrev_reorder_if.slave bus
);
  localparam int LOG_N = $clog2(N);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  typedef logic [LOG_N-1:0] idx_t;

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < LOG_N; i++) r[LOG_N-1-i] = v[i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [2*N];

  idx_t       wc_q;
  idx_t       rc_q;
  logic       wb_q;
  logic       rb_q;
  logic [1:0] full_q;
  logic [0:0] state_q;

  logic wr_last;
  logic rd_fire;
  logic rd_last;

  logic [2*WIDTH-1:0]      rd_data_p1;
  logic                    vld_p1;
  logic                    sof_p1;
  logic                    vld_p2;
  logic                    sof_p2;
  logic signed [WIDTH-1:0] re_p2;
  logic signed [WIDTH-1:0] im_p2;

  assign wr_last = bus.di_en && (wc_q == idx_t'(N-1));
  // The first read of a frame is issued from IDLE on the cycle the full flag
  // is seen, so bin 0 leaves two edges after the frame's last input.
  assign rd_fire = (state_q == ST_READ) || ((state_q == ST_IDLE) && full_q[rb_q]);
  assign rd_last = (state_q == ST_READ) && (rc_q == idx_t'(N-1));

  // Write side: scatter incoming samples to their natural-order slots
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wc_q <= '0;
      wb_q <= 1'b0;
    end else if (bus.di_en) begin
      wc_q <= wc_q + idx_t'(1);
      if (wr_last) wb_q <= ~wb_q;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.di_en) mem[{wb_q, bitrev(wc_q)}] <= {bus.di_re, bus.di_im};
  end

  // Writer and reader always touch different banks, so set and clear never collide
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
    end else begin
      if (wr_last) full_q[wb_q] <= 1'b1;
      if (rd_last) full_q[rb_q] <= 1'b0;
    end
  end

  // Read side FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rc_q    <= '0;
      rb_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (full_q[rb_q]) begin
            state_q <= ST_READ;
            rc_q    <= idx_t'(1);
          end
        end
        ST_READ: begin
          rc_q <= rc_q + idx_t'(1);
          if (rd_last) begin
            rb_q <= ~rb_q;
            if (!full_q[~rb_q]) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: synchronous memory read
  always_ff @(posedge clock) begin
    if (rd_fire) rd_data_p1 <= mem[{rb_q, rc_q}];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_fire;
      sof_p1 <= rd_fire && (rc_q == '0);
    end
  end

  // Stage p2: output register, data gated to zero while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
      re_p2  <= '0;
      im_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
      re_p2  <= vld_p1 ? rd_data_p1[2*WIDTH-1:WIDTH] : '0;
      im_p2  <= vld_p1 ? rd_data_p1[WIDTH-1:0] : '0;
    end
  end

  assign bus.do_en  = vld_p2;
  assign bus.do_sof = sof_p2;
  assign bus.do_re  = re_p2;
  assign bus.do_im  = im_p2;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed scenarios plus a randomized
// duty-cycle run against a frame-level reordering model.
module tb_fft_bitrev_reorder;
  localparam int N  = 64;
  localparam int W  = 16;
  localparam int N2 = 16;
  localparam int W2 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.WIDTH(W))  bus ();
  fft_bitrev_reorder_if #(.WIDTH(W2)) bus2 ();

  fft_bitrev_reorder #(.N(N),  .WIDTH(W))  dut  (.clock(clk), .reset(rst_n), .bus(bus));
  fft_bitrev_reorder #(.N(N2), .WIDTH(W2)) dut2 (.clock(clk), .reset(rst_n), .bus(bus2));

  typedef struct { int cyc; logic [W-1:0] re; logic [W-1:0] im; logic sof; } obs_t;
  typedef struct { int cyc; logic [W2-1:0] re; logic [W2-1:0] im; logic sof; } obs2_t;

  obs_t  oq[$];
  obs2_t o2q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int zero_viol = 0;
  int full_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.do_en) oq.push_back('{cyc, bus.do_re, bus.do_im, bus.do_sof});
    else if (bus.do_re !== '0 || bus.do_im !== '0 || bus.do_sof !== 1'b0) zero_viol++;
    if (bus2.do_en) o2q.push_back('{cyc, bus2.do_re, bus2.do_im, bus2.do_sof});
    else if (bus2.do_re !== '0 || bus2.do_im !== '0 || bus2.do_sof !== 1'b0) zero_viol++;
  end

  // A write must never land in a bank the reader has not yet drained
  always @(posedge clk) begin
    if (rst_n && bus.di_en && dut.full_q[dut.wb_q]) full_viol++;
    if (rst_n && bus2.di_en && dut2.full_q[dut2.wb_q]) full_viol++;
  end

  function automatic int brev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) r = r * 2 + ((v / (1 << i)) % 2);
    return r;
  endfunction

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    bus.di_en = 1'b1;
    bus.di_re = re;
    bus.di_im = im;
    @(posedge clk); #1;
    bus.di_en = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.di_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.do_en !== 1'b0)  begin errors++; $display("FAIL reset_do_en got %b want 0", bus.do_en); end
    if (bus.do_sof !== 1'b0) begin errors++; $display("FAIL reset_do_sof got %b want 0", bus.do_sof); end
    if (bus.do_re !== '0)    begin errors++; $display("FAIL reset_do_re got %h want 0", bus.do_re); end
    if (bus.do_im !== '0)    begin errors++; $display("FAIL reset_do_im got %h want 0", bus.do_im); end
    if (bus2.do_en !== 1'b0) begin errors++; $display("FAIL reset_do_en_small got %b want 0", bus2.do_en); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    oq.delete();
    idle(6);
    checks++;
    if (oq.size() !== 0) begin errors++; $display("FAIL reset_quiet got %0d outputs want 0", oq.size()); end
  endtask

  task automatic test_single_frame;
    int s;
    oq.delete();
    s = cyc;
    for (int k = 0; k < N; k++) send(W'(brev(k, 6)), W'(-brev(k, 6)));
    idle(N + 6);
    checks++;
    if (oq.size() !== N) begin errors++; $display("FAIL single_count got %0d want %0d", oq.size(), N); end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      checks++;
      if (oq[k].re !== W'(k) || oq[k].im !== W'(-k) || oq[k].sof !== (k == 0) || oq[k].cyc !== s + N + 2 + k) begin
        errors++;
        $display("FAIL single_bin %0d got re=%h im=%h sof=%b cyc=%0d want re=%h im=%h sof=%b cyc=%0d",
                 k, oq[k].re, oq[k].im, oq[k].sof, oq[k].cyc, W'(k), W'(-k), k == 0, s + N + 2 + k);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s;
    logic [W-1:0] imv [3*N];
    logic [W-1:0] ere, eim;
    oq.delete();
    s = cyc;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) begin
        imv[f*N + k] = W'($urandom);
        send(W'(f * 100 + brev(k, 6)), imv[f*N + k]);
      end
    idle(N + 6);
    checks++;
    if (oq.size() !== 3*N) begin errors++; $display("FAIL b2b_count got %0d want %0d", oq.size(), 3*N); end
    for (int i = 0; i < 3*N && i < oq.size(); i++) begin
      ere = W'((i / N) * 100 + (i % N));
      eim = imv[(i / N) * N + brev(i % N, 6)];
      checks++;
      if (oq[i].re !== ere || oq[i].im !== eim || oq[i].sof !== (i % N == 0) || oq[i].cyc !== s + N + 2 + i) begin
        errors++;
        $display("FAIL b2b_out %0d got re=%h im=%h sof=%b cyc=%0d want re=%h im=%h sof=%b cyc=%0d",
                 i, oq[i].re, oq[i].im, oq[i].sof, oq[i].cyc, ere, eim, i % N == 0, s + N + 2 + i);
      end
    end
  endtask

  task automatic test_gap;
    int s;
    oq.delete();
    s = cyc;
    for (int k = 0; k < N; k++) begin
      send(W'(brev(k, 6)), W'(-brev(k, 6)));
      if (k == 20) idle(5);
    end
    idle(N + 6);
    checks++;
    if (oq.size() !== N) begin errors++; $display("FAIL gap_count got %0d want %0d", oq.size(), N); end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      checks++;
      if (oq[k].re !== W'(k) || oq[k].im !== W'(-k) || oq[k].sof !== (k == 0) || oq[k].cyc !== s + N + 7 + k) begin
        errors++;
        $display("FAIL gap_bin %0d got re=%h im=%h sof=%b cyc=%0d want re=%h im=%h sof=%b cyc=%0d",
                 k, oq[k].re, oq[k].im, oq[k].sof, oq[k].cyc, W'(k), W'(-k), k == 0, s + N + 7 + k);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    int drained;
    logic [W-1:0] fr [N];
    logic [W-1:0] fi [N];
    oq.delete();
    for (int k = 0; k < N; k++) send(W'($urandom), W'($urandom));
    for (int k = 0; k < 30; k++) send(W'($urandom), W'($urandom));
    drained = oq.size();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (drained <= 0 || drained >= N) begin errors++; $display("FAIL midrst_draining got %0d outputs want 1..%0d", drained, N-1); end
    if (bus.do_en !== 1'b0) begin errors++; $display("FAIL midrst_do_en got %b want 0", bus.do_en); end
    if (bus.do_re !== '0)   begin errors++; $display("FAIL midrst_do_re got %h want 0", bus.do_re); end
    if (bus.do_im !== '0)   begin errors++; $display("FAIL midrst_do_im got %h want 0", bus.do_im); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    oq.delete();
    s = cyc;
    for (int k = 0; k < N; k++) begin
      fr[brev(k, 6)] = W'($urandom);
      fi[brev(k, 6)] = W'($urandom);
      send(fr[brev(k, 6)], fi[brev(k, 6)]);
    end
    idle(N + 6);
    checks++;
    if (oq.size() !== N) begin errors++; $display("FAIL midrst_count got %0d want %0d", oq.size(), N); end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      checks++;
      if (oq[k].re !== fr[k] || oq[k].im !== fi[k] || oq[k].sof !== (k == 0) || oq[k].cyc !== s + N + 2 + k) begin
        errors++;
        $display("FAIL midrst_bin %0d got re=%h im=%h sof=%b cyc=%0d want re=%h im=%h sof=%b cyc=%0d",
                 k, oq[k].re, oq[k].im, oq[k].sof, oq[k].cyc, fr[k], fi[k], k == 0, s + N + 2 + k);
      end
    end
  endtask

  task automatic test_small_width;
    int s;
    logic [W2-1:0] er [N2];
    logic [W2-1:0] ei [N2];
    for (int j = 0; j < N2; j++) begin
      er[j] = (j % 2 == 0) ? W2'(8'h80 + j) : W2'(8'h7F - j);
      ei[j] = (j % 4 < 2) ? 8'h7F : 8'h80;
    end
    o2q.delete();
    s = cyc;
    for (int k = 0; k < N2; k++) begin
      bus2.di_en = 1'b1;
      bus2.di_re = er[brev(k, 4)];
      bus2.di_im = ei[brev(k, 4)];
      @(posedge clk); #1;
    end
    bus2.di_en = 1'b0;
    repeat (N2 + 6) begin @(posedge clk); #1; end
    checks++;
    if (o2q.size() !== N2) begin errors++; $display("FAIL small_count got %0d want %0d", o2q.size(), N2); end
    for (int j = 0; j < N2 && j < o2q.size(); j++) begin
      checks++;
      if (o2q[j].re !== er[j] || o2q[j].im !== ei[j] || o2q[j].sof !== (j == 0) || o2q[j].cyc !== s + N2 + 2 + j) begin
        errors++;
        $display("FAIL small_bin %0d got re=%h im=%h sof=%b cyc=%0d want re=%h im=%h sof=%b cyc=%0d",
                 j, o2q[j].re, o2q[j].im, o2q[j].sof, o2q[j].cyc, er[j], ei[j], j == 0, s + N2 + 2 + j);
      end
    end
  endtask

  task automatic test_random;
    localparam int F = 50;
    obs_t eq[$];
    logic [W-1:0] fr [N];
    logic [W-1:0] fi [N];
    oq.delete();
    for (int f = 0; f < F; f++) begin
      for (int k = 0; k < N; k++) begin
        fr[k] = W'($urandom);
        fi[k] = W'($urandom);
      end
      // Input slot k carries bin brev(k), so natural bin j is input slot brev(j)
      for (int j = 0; j < N; j++) eq.push_back('{0, fr[brev(j, 6)], fi[brev(j, 6)], j == 0});
      for (int k = 0; k < N; k++) begin
        while ($urandom_range(0, 3) == 0) idle(1);
        send(fr[k], fi[k]);
      end
    end
    for (int t = 0; t < 4*N && oq.size() < F*N; t++) idle(1);
    idle(4);
    checks++;
    if (oq.size() !== eq.size()) begin errors++; $display("FAIL random_count got %0d want %0d", oq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
      checks++;
      if (oq[i].re !== eq[i].re || oq[i].im !== eq[i].im || oq[i].sof !== eq[i].sof) begin
        errors++;
        $display("FAIL random_out %0d got re=%h im=%h sof=%b want re=%h im=%h sof=%b",
                 i, oq[i].re, oq[i].im, oq[i].sof, eq[i].re, eq[i].im, eq[i].sof);
      end
    end
    checks += 2;
    if (zero_viol !== 0) begin errors++; $display("FAIL idle_zero got %0d nonzero idle cycles want 0", zero_viol); end
    if (full_viol !== 0) begin errors++; $display("FAIL write_into_full got %0d events want 0", full_viol); end
  endtask

  initial begin
    bus.di_en  = 1'b0;
    bus.di_re  = '0;
    bus.di_im  = '0;
    bus2.di_en = 1'b0;
    bus2.di_re = '0;
    bus2.di_im = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_small_width();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
